sha256_compress_core: RTL
=========================

# sha256_compress_core

Single-block SHA-256 compression engine that the bitcoin hashing FSM instantiates once per nonce lane and drives with a start/done handshake. It accepts one 512-bit message block plus a 256-bit chaining value, or the standard IV, and runs the 64 SHA-256 rounds at one round per cycle. It returns the updated 256-bit chaining value. Chaining over multiple blocks, such as the two-block header hash followed by the second-pass hash, is the caller's responsibility: the caller feeds `hash_out` back into `hash_in`.

## Interface
- No parameters. K[0..63] and IV H0..H7 are fixed internal constant tables, per FIPS 180-4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `use_iv`  in  1  sampled with `start`. 1 = chain value is the standard IV (6a09e667 … 5be0cd19); 0 = chain value is `hash_in`.
- `block_in`  in  512  message block; word 0 = `[511:480]`, word 15 = `[31:0]`. Sampled with `start`.
- `hash_in`  in  256  chaining value; H0 = `[255:224]`. Sampled with `start`.
- `busy`  out  1  high while a block is in flight.
- `done`  out  1  single-cycle pulse; `hash_out` is valid from this cycle.
- `hash_out`  out  256  registered result, H0 in `[255:224]`. Holds until the next `done`.

## Operation
- States: IDLE → ROUND → FINAL → IDLE.
- IDLE:
  - On `start`, capture the chain value (H[0..7] regs) and initialise a..h = chain.
  - Load the 16-word W window from `block_in`, set round counter t = 0, and go to ROUND.
  - `start` is ignored outside IDLE, with no queueing.
- ROUND, one round per cycle, t = 0..63:
  - Round word Wt:
    - t < 16: window word t.
    - t ≥ 16: σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - The window is a 16-deep shift register. Each round shifts in the new word and drops the oldest.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + Wt.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - When t = 63, go to FINAL.
- FINAL:
  - `hash_out[i]` = H[i] + {a..h}[i], for i = 0..7.
  - Assert `done` and return to IDLE.
- Function definitions:
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
  - σ0 = ROTR7^ROTR18^SHR3.
  - σ1 = ROTR17^ROTR19^SHR10.
  - Ch = (e&f)^(~e&g).
  - Maj = (a&b)^(a&c)^(b&c).
- Arithmetic: all additions are mod 2^32; carries out of bit 31 are discarded.
- No padding is performed. The caller supplies already-padded blocks.

## Timing
- Reset values: `busy` = 0, `done` = 0, `hash_out` = 0, state = IDLE, t = 0.
- Reset mid-operation:
  - Next cycle is IDLE with outputs at reset values.
  - The in-flight block is discarded and no `done` is produced.
  - Reset has priority over `start` in the same cycle.
- Latency:
  - `start` sampled high in cycle 0.
  - `busy` is high in cycles 1–65: 64 ROUND cycles plus FINAL.
  - `done` and the new `hash_out` appear in cycle 66.
  - `busy` is low in cycle 66.
- Back-to-back: `start` may be asserted in the `done` cycle (cycle 66). It is accepted, and that block's `done` appears in cycle 132.
- Inputs are don't-care except in the `start`-sampled cycle.
- Throughput: one block per 66 cycles.
- `done` is never high for two consecutive cycles.

## Test plan
- **"abc":** `use_iv`=1, `block_in` = 61626380, 14×00000000, 00000018.
  - `done` in cycle 66.
  - `hash_out` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **Empty string:** `use_iv`=1, `block_in` = 80000000 followed by zeros.
  - `hash_out` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Two-block chaining** of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 with `use_iv`=1.
  - Block 2 (80000000, zeros, final word 000001c0) with `use_iv`=0 and `hash_in` = block-1 `hash_out`, started in the `done` cycle of block 1.
  - Final `hash_out` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, with `done` in cycle 132.
- **Start while busy:**
  - Start "abc", then pulse `start` with the empty-string block in cycle 30.
  - Exactly one `done`, in cycle 66, with the "abc" digest; `busy` stays high in cycles 1–65.
- **Reset mid-operation:**
  - Assert `reset` in cycle 40 of an "abc" run.
  - In cycle 41, `busy` = 0, `done` = 0, `hash_out` = 0, and no `done` follows.
  - A new empty-string start afterwards produces the correct digest 66 cycles later.

Source files
------------

// File: rtl/sha256_compress_core.sv
// Single-block SHA-256 compression: 64 rounds at one round per cycle, then a
// final chain-add. Caller chains multiple blocks through hash_in/hash_out.
//   S_IDLE  | waiting for start; captures chain value and message block
//   S_ROUND | one compression round per cycle, t = 0..63
//   S_FINAL | adds working vars into the chain value, pulses done
module sha256_compress_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         use_iv,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic         done_q, done_d;
  logic [255:0] hash_out_q, hash_out_d;
  logic [31:0]  h_q [8];
  logic [31:0]  h_d [8];
  logic [31:0]  v_q [8];
  logic [31:0]  v_d [8];
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];

  logic [255:0] chain;
  logic [31:0]  t1, t2, w_next;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    done_d     = 1'b0;
    hash_out_d = hash_out_q;
    h_d        = h_q;
    v_d        = v_q;
    w_d        = w_q;

    chain  = use_iv ? IV : hash_in;
    t1     = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[t_q] + w_q[0];
    t2     = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    // w_q[0] is always the current round word; push the word needed 16 rounds on
    w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            h_d[i] = chain[255 - 32*i -: 32];
            v_d[i] = chain[255 - 32*i -: 32];
          end
          for (int i = 0; i < 16; i++) w_d[i] = block_in[511 - 32*i -: 32];
          t_d     = 6'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        for (int i = 7; i > 0; i--) v_d[i] = v_q[i-1];
        v_d[4] = v_q[3] + t1;
        v_d[0] = t1 + t2;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_next;
        t_d     = t_q + 6'd1;
        if (t_q == 6'd63) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) hash_out_d[255 - 32*i -: 32] = h_q[i] + v_q[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      t_q        <= 6'd0;
      done_q     <= 1'b0;
      hash_out_q <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      done_q     <= done_d;
      hash_out_q <= hash_out_d;
    end
  end

  // Datapath contents are only meaningful after a start, so they need no reset
  always_ff @(posedge clk) begin
    h_q <= h_d;
    v_q <= v_d;
    w_q <= w_d;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hash_out = hash_out_q;

endmodule
